// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared types and constants for the BCD converter scheduler.
package bcd_conv_scheduler_pkg;

   localparam int DATA_W       = 7;
   localparam int DIGIT_W      = 4;
   localparam int DEF_N_REQ    = 4;
   localparam int DEF_CONV_LAT = 1;

   // Largest legal single BCD digit; anything above marks a 3-digit value.
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAPT = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_conv_scheduler_if.sv
// Bus between the scheduler and its surroundings: the requesters and the
// shared binary-to-BCD converter. The master side is that surrounding logic.
interface bcd_conv_scheduler_if
   import bcd_conv_scheduler_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
) ();

   logic [N_REQ-1:0]        req;
   logic [DATA_W*N_REQ-1:0] req_data;
   logic [DATA_W-1:0]       conv_hexa;
   logic [DIGIT_W-1:0]      conv_tens;
   logic [DIGIT_W-1:0]      conv_units;
   logic [N_REQ-1:0]        done;
   logic [DIGIT_W-1:0]      res_tens;
   logic [DIGIT_W-1:0]      res_units;
   logic                    res_ovf;
   logic                    busy;

   modport master (
      output req, req_data, conv_tens, conv_units,
      input  conv_hexa, done, res_tens, res_units, res_ovf, busy
   );

   modport slave (
      input  req, req_data, conv_tens, conv_units,
      output conv_hexa, done, res_tens, res_units, res_ovf, busy
   );

endinterface

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant,
// wrapping around. Reusable for any shared display resource.
module rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   logic [IDX_W-1:0] idx;

   // Scan from last_grant+1 upward; the first hit wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = IDX_W'((int'(last_grant) + i) % N_REQ);
         if (!valid && req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Time-shares one registered binary-to-BCD converter between N_REQ
// requesters, returning captured digits with a one-cycle done pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no conversion in flight; grant the next requester, if any
// ST_WAIT | converter input driven, counting out its latency
// ST_CAPT | converter digits valid; capture them and pulse done
module bcd_conv_scheduler
   import bcd_conv_scheduler_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int CONV_LAT = DEF_CONV_LAT
) (
   input logic                  clk,
   input logic                  reset,
   bcd_conv_scheduler_if.slave  bus
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_LAT - 1);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   gnt_idx, last_grant, winner;
   logic               win_valid;
   logic [CNT_W-1:0]   cnt;
   logic [N_REQ-1:0]   eff_req;
   logic [N_REQ-1:0]   done_q;
   logic [DATA_W-1:0]  hexa_q;
   logic [DIGIT_W-1:0] tens_q, units_q;
   logic               ovf_q;
   logic [DATA_W-1:0]  slot [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_slot
      assign slot[g] = bus.req_data[g*DATA_W +: DATA_W];
   end

   // A requester is not re-granted in the very cycle its done is showing.
   assign eff_req = bus.req & ~done_q;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req        (eff_req),
      .last_grant (last_grant),
      .winner     (winner),
      .valid      (win_valid)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and busy flag.
   always_comb begin
      state_nxt = state;
      bus.busy  = 1'b0;
      case (state)
         ST_IDLE: if (win_valid) state_nxt = ST_WAIT;
         ST_WAIT: begin
            bus.busy = 1'b1;
            if (cnt == CNT_LAST) state_nxt = ST_CAPT;
         end
         ST_CAPT: begin
            bus.busy  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Grant bookkeeping, latency counter and result capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_idx    <= '0;
         last_grant <= IDX_W'(N_REQ - 1);
         cnt        <= '0;
         hexa_q     <= '0;
         done_q     <= '0;
         tens_q     <= '0;
         units_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         done_q <= '0;
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  gnt_idx    <= winner;
                  last_grant <= winner;
                  hexa_q     <= slot[winner];
                  cnt        <= '0;
               end
            end
            ST_WAIT: cnt <= cnt + 1'b1;
            ST_CAPT: begin
               tens_q  <= bus.conv_tens;
               units_q <= bus.conv_units;
               ovf_q   <= (bus.conv_tens > BCD_MAX);
               done_q  <= N_REQ'(1) << gnt_idx;
            end
            default: ;
         endcase
      end
   end

   assign bus.conv_hexa = hexa_q;
   assign bus.done      = done_q;
   assign bus.res_tens  = tens_q;
   assign bus.res_units = units_q;
   assign bus.res_ovf   = ovf_q;

endmodule
